// File: rtl/uart_bip_pkg.sv
// Shared definitions for the UART <-> BIP command sequencer: state encoding,
// instruction field widths and the error reply word.
package uart_bip_pkg;

    localparam int OPC_W   = 5;
    localparam int OPR_W   = 11;
    localparam int INSTR_W = OPC_W + OPR_W;
    localparam int ACC_W   = 16;

    localparam logic [ACC_W-1:0] ERR_REPLY = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_B1  = 3'd1,
        ST_EXEC     = 3'd2,
        ST_WAIT_BIP = 3'd3,
        ST_TX_LO    = 3'd4,
        ST_WAIT_LO  = 3'd5,
        ST_TX_HI    = 3'd6,
        ST_WAIT_HI  = 3'd7
    } state_e;

endpackage

// File: rtl/uart_bip_timer.sv
// Saturating timeout counter shared by the inter-byte and BIP-completion waits.
// expire is high once the count reaches TIMEOUT_CYCLES-1.
module uart_bip_timer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/uart_bip_ctrl.sv
// Command sequencer: two received bytes form a BIP instruction, one BIP run is
// launched, and the 16-bit accumulator is returned low byte first.
module uart_bip_ctrl
    import uart_bip_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done,
    input  logic [7:0]         uart_to_bip,
    input  logic               tx_done,
    output logic               tx_start,
    output logic [7:0]         bip_to_uart,
    output logic               bip_start,
    output logic [INSTR_W-1:0] bip_instr,
    input  logic               bip_done,
    input  logic [ACC_W-1:0]   bip_acc,
    output logic               busy,
    output logic               timeout_err,
    output logic               overrun_err,
    output logic [2:0]         state_dbg
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         res_hi_q, res_hi_d;
    logic               tmo_q, tmo_d;
    logic               ovr_q, ovr_d;
    logic               bip_start_q, tx_start_q, busy_q;
    logic               tmr_clr, tmr_en, tmr_expire;

    uart_bip_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        data_d   = data_q;
        res_hi_d = res_hi_q;
        tmo_d    = tmo_q;
        ovr_d    = ovr_q;
        tmr_clr  = 1'b0;
        tmr_en   = (state_q == ST_WAIT_B1) || (state_q == ST_WAIT_BIP);

        case (state_q)
            ST_IDLE: if (rx_done) begin
                instr_d[15:8] = uart_to_bip;
                tmo_d         = 1'b0;
                ovr_d         = 1'b0;
                tmr_clr       = 1'b1;
                state_d       = ST_WAIT_B1;
            end
            // A byte landing on the expiry cycle still completes the command.
            ST_WAIT_B1: if (rx_done) begin
                instr_d[7:0] = uart_to_bip;
                state_d      = ST_EXEC;
            end else if (tmr_expire) begin
                tmo_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_EXEC: begin
                tmr_clr = 1'b1;
                state_d = ST_WAIT_BIP;
            end
            // The low byte goes straight to the output so it is valid with tx_start.
            ST_WAIT_BIP: if (bip_done) begin
                data_d   = bip_acc[7:0];
                res_hi_d = bip_acc[15:8];
                state_d  = ST_TX_LO;
            end else if (tmr_expire) begin
                tmo_d    = 1'b1;
                data_d   = ERR_REPLY[7:0];
                res_hi_d = ERR_REPLY[15:8];
                state_d  = ST_TX_LO;
            end
            ST_TX_LO:   state_d = ST_WAIT_LO;
            ST_WAIT_LO: if (tx_done) begin
                data_d  = res_hi_q;
                state_d = ST_TX_HI;
            end
            ST_TX_HI:   state_d = ST_WAIT_HI;
            ST_WAIT_HI: if (tx_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (rx_done && state_q != ST_IDLE && state_q != ST_WAIT_B1) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            data_q      <= '0;
            res_hi_q    <= '0;
            tmo_q       <= 1'b0;
            ovr_q       <= 1'b0;
            bip_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            res_hi_q    <= res_hi_d;
            tmo_q       <= tmo_d;
            ovr_q       <= ovr_d;
            bip_start_q <= (state_d == ST_EXEC);
            tx_start_q  <= (state_d == ST_TX_LO) || (state_d == ST_TX_HI);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign tx_start    = tx_start_q;
    assign bip_to_uart = data_q;
    assign bip_start   = bip_start_q;
    assign bip_instr   = instr_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;
    assign overrun_err = ovr_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/uart_bip_ctrl.md
Name: uart_bip_ctrl

Overview:
Command sequencer between the UART core and the BIP processor. Collects a 2-byte instruction from the receiver, launches one BIP execution, waits for completion, then returns the 16-bit accumulator as 2 bytes through the transmitter. A stalled command or a hung BIP is aborted by a timeout. A byte that arrives while a command is executing is flagged as an overrun.

Parameters:
TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes 0 and 1, and from bip_start to bip_done.
CNT_W, 20, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
rx_done  in  1  one-cycle pulse; uart_to_bip holds a valid byte
uart_to_bip  in  8  received byte
tx_done  in  1  one-cycle pulse; transmitter finished a byte
tx_start  out  1  one-cycle pulse; launch transmission of bip_to_uart
bip_to_uart  out  8  byte to transmit; stable from tx_start until tx_done
bip_start  out  1  one-cycle pulse; execute bip_instr
bip_instr  out  16  {opcode[4:0], operand[10:0]}
bip_done  in  1  one-cycle pulse; BIP finished, bip_acc valid
bip_acc  in  16  BIP accumulator
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky; set on a timeout
overrun_err  out  1  sticky; set when rx_done arrives outside IDLE/WAIT_B1
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, active-low):
  - state=IDLE.
  - All outputs 0: tx_start, bip_start, bip_instr, bip_to_uart, busy, timeout_err, overrun_err.
  - Timeout counter 0.
- States and encodings: IDLE=0, WAIT_B1=1, EXEC=2, WAIT_BIP=3, TX_LO=4, WAIT_LO=5, TX_HI=6, WAIT_HI=7.
- IDLE:
  - On rx_done: bip_instr[15:8]<=uart_to_bip; clear timeout_err and overrun_err; go to WAIT_B1; counter<=0.
- WAIT_B1:
  - On rx_done: bip_instr[7:0]<=uart_to_bip; go to EXEC.
  - Else, when counter==TIMEOUT_CYCLES-1: timeout_err<=1; go to IDLE. The partial command is discarded and bip_instr keeps its value.
- EXEC:
  - bip_start=1 for exactly this one cycle.
  - Go to WAIT_BIP; counter<=0.
- WAIT_BIP:
  - bip_done is sampled here only. A bip_done during EXEC is ignored.
  - On bip_done: latch bip_acc into a result register; go to TX_LO.
  - On timeout: timeout_err<=1; result<=16'hFFFF; go to TX_LO. The host always receives a 2-byte reply.
- TX_LO:
  - bip_to_uart<=result[7:0]; tx_start=1 for one cycle.
  - Go to WAIT_LO.
- WAIT_LO:
  - On tx_done: go to TX_HI.
  - No timeout in this state. The transmitter is guaranteed to complete.
- TX_HI:
  - bip_to_uart<=result[15:8]; tx_start pulse.
  - Go to WAIT_HI.
- WAIT_HI:
  - On tx_done: go to IDLE.
- Latency:
  - bip_start is asserted exactly 1 cycle after the rx_done of byte 1.
  - tx_start (low byte) is asserted exactly 1 cycle after bip_done.
- Overrun:
  - rx_done in states 2–7 sets overrun_err. The byte is dropped and the state is unaffected.
- Simultaneous events:
  - rx_done and the timeout threshold in the same WAIT_B1 cycle: rx_done wins and no error is raised.
  - bip_done and the timeout in the same cycle: bip_done wins.
- Counter:
  - Runs only in WAIT_B1 and WAIT_BIP; saturates and does not wrap.
  - Cleared on every state entry into those states.
- busy = (state != IDLE), registered together with the state.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - A tx_start or bip_start pulse in progress is cut.

Decomposition:
- Shared package uart_bip_pkg:
  - State encoding constants (3-bit).
  - Opcode field widths OPC_W=5, OPR_W=11.
  - Error reply constant 16'hFFFF.
- One sub-module, uart_bip_timer:
  - Loadable saturating counter: clear, enable, expire output at TIMEOUT_CYCLES-1.
  - Instantiated once and shared between WAIT_B1 and WAIT_BIP.

Test Plan:
- Normal command:
  - Stimulus: rx bytes 8'h0A then 8'h05; bip_done 10 cycles after bip_start with bip_acc=16'h1234.
  - Response: bip_instr=16'h0A05; bip_start is a single pulse 1 cycle after the 2nd rx_done; tx sends 8'h34 then 8'h12; busy drops after the 2nd tx_done.
- Inter-byte timeout (TIMEOUT_CYCLES=50):
  - Stimulus: one byte only.
  - Response: after 50 cycles, timeout_err=1, state=IDLE, no bip_start, no tx_start.
- BIP hang (TIMEOUT_CYCLES=50):
  - Stimulus: bip_done never arrives.
  - Response: timeout_err=1; tx sends 8'hFF then 8'hFF; next command's first rx_done clears timeout_err.
- Overrun:
  - Stimulus: extra rx_done 8'h77 during WAIT_BIP.
  - Response: overrun_err=1; bip_instr is unchanged; reply completes normally.
- Boundary race:
  - Stimulus: 2nd rx_done exactly on the timeout cycle.
  - Response: command executes and timeout_err stays 0.
- Reset mid-transmit:
  - Stimulus: assert reset low during WAIT_LO.
  - Response: all outputs go to 0 asynchronously; after release, state=IDLE and the next command works.
